// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared mode bits, half-width helper and group PG record for cla_pipe_adder
package cla_pkg;

  localparam int MODE_SUB_BIT    = 0;
  localparam int MODE_SIGNED_BIT = 1;

  typedef struct packed {
    logic g;
    logic p;
  } pg_t;

  function automatic int half_width(input int width);
    return width / 2;
  endfunction

endpackage

// File: rtl/cla_group.sv
// rtl/cla_group.sv - GROUP-bit carry-lookahead block producing sum plus group generate/propagate
module cla_group
  import cla_pkg::*;
#(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] sum,
  output pg_t              pg
);

  logic [GROUP-1:0] g;
  logic [GROUP-1:0] p;
  logic [GROUP-1:0] c;

  assign g = a & b;
  assign p = a | b;

  // Group G/P kept apart from the sum path so they never depend on cin.
  always_comb begin
    pg.p = &p;
    pg.g = 1'b0;
    for (int i = 0; i < GROUP; i++) begin
      pg.g = g[i] | (p[i] & pg.g);
    end
  end

  always_comb begin
    c    = '0;
    c[0] = cin;
    for (int i = 1; i < GROUP; i++) begin
      c[i] = g[i-1] | (p[i-1] & c[i-1]);
    end
    sum = a ^ b ^ c;
  end

endmodule

// File: rtl/cla_pipe_adder.sv
// rtl/cla_pipe_adder.sv - two-stage CLA add/sub with valid/ready; CLA_SAT_EN enables signed saturation
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int GROUP = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_add1,
  input  logic [WIDTH-1:0] i_add2,
  input  logic [1:0]       i_mode,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH:0]   o_result,
  output logic             o_ovf
);

  localparam int HALF = half_width(WIDTH);
  localparam int NG   = HALF / GROUP;

  logic             s1_v;
  logic             s2_v;
  logic             s1_load;
  logic             s2_load;
  logic             accept;

  logic [WIDTH-1:0] b_cond;
  logic [HALF-1:0]  lo_sum;
  logic [HALF-1:0]  hi_sum;
  pg_t  [NG-1:0]    lo_pg;
  pg_t  [NG-1:0]    hi_pg;
  logic [NG:0]      lo_c;
  logic [NG:0]      hi_c;

  logic [HALF-1:0]  s1_sum_lo;
  logic             s1_c_lo;
  logic [HALF-1:0]  s1_a_hi;
  logic [HALF-1:0]  s1_b_hi;
  logic [1:0]       s1_mode;

  logic             cout;
  logic             c_msb;
  logic             ovf_n;
  logic             top_n;
  logic [WIDTH-1:0] sum_n;

  assign s2_load = !s2_v || i_ready;
  assign s1_load = !s1_v || s2_load;
  assign o_ready = !s1_v || s2_load;
  assign accept  = i_valid && o_ready;
  assign o_valid = s2_v;

  assign b_cond = i_mode[MODE_SUB_BIT] ? ~i_add2 : i_add2;

  genvar k;
  for (k = 0; k < NG; k++) begin : g_lo
    cla_group #(.GROUP(GROUP)) u_grp (
      .a   (i_add1[k*GROUP +: GROUP]),
      .b   (b_cond[k*GROUP +: GROUP]),
      .cin (lo_c[k]),
      .sum (lo_sum[k*GROUP +: GROUP]),
      .pg  (lo_pg[k])
    );
  end

  for (k = 0; k < NG; k++) begin : g_hi
    cla_group #(.GROUP(GROUP)) u_grp (
      .a   (s1_a_hi[k*GROUP +: GROUP]),
      .b   (s1_b_hi[k*GROUP +: GROUP]),
      .cin (hi_c[k]),
      .sum (hi_sum[k*GROUP +: GROUP]),
      .pg  (hi_pg[k])
    );
  end

  // Group-level lookahead within each half; the halves meet only through s1_c_lo.
  always_comb begin
    lo_c    = '0;
    lo_c[0] = i_mode[MODE_SUB_BIT];
    for (int i = 0; i < NG; i++) begin
      lo_c[i+1] = lo_pg[i].g | (lo_pg[i].p & lo_c[i]);
    end
  end

  always_comb begin
    hi_c    = '0;
    hi_c[0] = s1_c_lo;
    for (int i = 0; i < NG; i++) begin
      hi_c[i+1] = hi_pg[i].g | (hi_pg[i].p & hi_c[i]);
    end
  end

  always_comb begin
    cout  = hi_c[NG];
    c_msb = hi_sum[HALF-1] ^ s1_a_hi[HALF-1] ^ s1_b_hi[HALF-1];
    ovf_n = s1_mode[MODE_SIGNED_BIT] & (c_msb ^ cout);
    sum_n = {hi_sum, s1_sum_lo};
    if (s1_mode[MODE_SIGNED_BIT]) begin
      top_n = s1_a_hi[HALF-1] ^ s1_b_hi[HALF-1] ^ cout;
    end else begin
      top_n = s1_mode[MODE_SUB_BIT] ? ~cout : cout;
    end
`ifdef CLA_SAT_EN
    if (ovf_n) begin
      sum_n = {s1_a_hi[HALF-1], {(WIDTH-1){~s1_a_hi[HALF-1]}}};
      top_n = s1_a_hi[HALF-1];
    end
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_v      <= 1'b0;
      s1_sum_lo <= '0;
      s1_c_lo   <= 1'b0;
      s1_a_hi   <= '0;
      s1_b_hi   <= '0;
      s1_mode   <= '0;
    end else if (s1_load) begin
      s1_v <= accept;
      if (accept) begin
        s1_sum_lo <= lo_sum;
        s1_c_lo   <= lo_c[NG];
        s1_a_hi   <= i_add1[WIDTH-1:HALF];
        s1_b_hi   <= b_cond[WIDTH-1:HALF];
        s1_mode   <= i_mode;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s2_v     <= 1'b0;
      o_result <= '0;
      o_ovf    <= 1'b0;
    end else if (s2_load) begin
      s2_v <= s1_v;
      if (s1_v) begin
        o_result <= {top_n, sum_n};
        o_ovf    <= ovf_n;
      end
    end
  end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb/tb_cla_pipe_adder.sv - directed table, backpressure, reset and random checks for cla_pipe_adder
module tb_cla_pipe_adder;

`ifdef CLA_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk;
  logic        i_rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [15:0] i_add1;
  logic [15:0] i_add2;
  logic [1:0]  i_mode;
  logic        o_valid;
  logic        i_ready;
  logic [16:0] o_result;
  logic        o_ovf;

  int checks   = 0;
  int failures = 0;
  int n_in     = 0;
  int n_out    = 0;
  bit took     = 0;
  logic [17:0] exp_q[$];

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  mode;
    logic [16:0] res_wrap;
    logic [16:0] res_sat;
    logic        ovf;
  } vec_t;

  vec_t vecs[10];

  cla_pipe_adder #(.WIDTH(16), .GROUP(4)) dut (
    .i_clk    (clk),
    .i_rst_n  (i_rst_n),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_add1   (i_add1),
    .i_add2   (i_add2),
    .i_mode   (i_mode),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_result (o_result),
    .o_ovf    (o_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Reference: true mathematical result, then wrapped or clamped into 17 bits.
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic [1:0] m);
    int ua;
    int ub;
    int r;
    logic ovf;
    logic [16:0] res;
    ovf = 1'b0;
    if (m[1]) begin
      ua = int'($signed(a));
      ub = int'($signed(b));
      r  = m[0] ? ua - ub : ua + ub;
      ovf = (r > 32767) || (r < -32768);
      if (SAT && ovf) r = (ua < 0) ? -32768 : 32767;
      res = r[16:0];
    end else begin
      ua = int'(a);
      ub = int'(b);
      if (m[0]) begin
        r = ua - ub;
        res = {ua < ub, r[15:0]};
      end else begin
        r = ua + ub;
        res = r[16:0];
      end
    end
    return {ovf, res};
  endfunction

  task automatic observe();
    logic [17:0] e;
    @(negedge clk);
    if (o_valid && i_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("stream_result", 32'(o_result), 32'(e[16:0]));
        chk("stream_ovf", 32'(o_ovf), 32'(e[17]));
      end
      n_out++;
    end
    took = i_valid && o_ready;
    if (took) begin
      exp_q.push_back(model(i_add1, i_add2, i_mode));
      n_in++;
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] rand_op();
    logic [15:0] edges[5];
    edges[0] = 16'h0000;
    edges[1] = 16'h0001;
    edges[2] = 16'h7FFF;
    edges[3] = 16'h8000;
    edges[4] = 16'hFFFF;
    if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 4)];
    return 16'($urandom);
  endfunction

  initial begin
    logic [16:0] held;
    logic [15:0] bp_a[3];
    logic [15:0] bp_b[3];
    logic [1:0]  bp_m[3];
    int k;
    int base;
    bit seen;

    vecs[0] = '{16'hFFFF, 16'h0001, 2'b00, 17'h10000, 17'h10000, 1'b0};
    vecs[1] = '{16'h0003, 16'h0005, 2'b01, 17'h1FFFE, 17'h1FFFE, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 2'b10, 17'h08000, 17'h07FFF, 1'b1};
    vecs[3] = '{16'h1234, 16'h4321, 2'b00, 17'h05555, 17'h05555, 1'b0};
    vecs[4] = '{16'h0005, 16'h0003, 2'b01, 17'h00002, 17'h00002, 1'b0};
    vecs[5] = '{16'h8000, 16'h0001, 2'b11, 17'h17FFF, 17'h18000, 1'b1};
    vecs[6] = '{16'hFFFF, 16'hFFFF, 2'b10, 17'h1FFFE, 17'h1FFFE, 1'b0};
    vecs[7] = '{16'h0000, 16'h0001, 2'b11, 17'h1FFFF, 17'h1FFFF, 1'b0};
    vecs[8] = '{16'h5A5A, 16'h5A5A, 2'b01, 17'h00000, 17'h00000, 1'b0};
    vecs[9] = '{16'h8000, 16'h8000, 2'b10, 17'h10000, 17'h18000, 1'b1};

    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_add1  = '0;
    i_add2  = '0;
    i_mode  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", 32'(o_valid), 32'd0);
    chk("reset_result", 32'(o_result), 32'd0);
    chk("reset_ovf", 32'(o_ovf), 32'd0);
    i_rst_n = 1'b1;
    advance();
    chk("ready_after_reset", 32'(o_ready), 32'd1);

    for (int i = 0; i < 10; i++) begin
      i_add1  = vecs[i].a;
      i_add2  = vecs[i].b;
      i_mode  = vecs[i].mode;
      i_valid = 1'b1;
      i_ready = 1'b1;
      advance();
      i_valid = 1'b0;
      chk("vec_latency_early", 32'(o_valid), 32'd0);
      advance();
      chk("vec_valid", 32'(o_valid), 32'd1);
      chk("vec_result", 32'(o_result), 32'(SAT ? vecs[i].res_sat : vecs[i].res_wrap));
      chk("vec_ovf", 32'(o_ovf), 32'(vecs[i].ovf));
      advance();
    end
    chk("vec_drained", 32'(o_valid), 32'd0);

    // Backpressure: three beats against a stalled consumer for four cycles.
    bp_a[0] = 16'h0102; bp_b[0] = 16'h0304; bp_m[0] = 2'b00;
    bp_a[1] = 16'h8000; bp_b[1] = 16'h0001; bp_m[1] = 2'b11;
    bp_a[2] = 16'h0001; bp_b[2] = 16'h0002; bp_m[2] = 2'b01;
    k = 0;
    base = n_out;
    held = '0;
    took = 1'b0;
    for (int cyc = 0; cyc < 30 && (n_out - base) < 3; cyc++) begin
      if (cyc == 0 || took) begin
        if (cyc != 0) k++;
        if (k < 3) begin
          i_add1 = bp_a[k];
          i_add2 = bp_b[k];
          i_mode = bp_m[k];
          i_valid = 1'b1;
        end else begin
          i_valid = 1'b0;
        end
      end
      i_ready = (cyc >= 4);
      observe();
      if (cyc == 2) begin
        chk("bp_full_ready", 32'(o_ready), 32'd0);
        chk("bp_full_valid", 32'(o_valid), 32'd1);
        held = o_result;
      end
      if (cyc == 3) begin
        chk("bp_still_full", 32'(o_ready), 32'd0);
        chk("bp_result_held", 32'(o_result), 32'(held));
      end
      advance();
    end
    i_valid = 1'b0;
    chk("bp_delivered", 32'(n_out - base), 32'd3);
    chk("bp_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset with two beats in flight.
    i_ready = 1'b0;
    i_add1 = 16'h1111; i_add2 = 16'h2222; i_mode = 2'b00; i_valid = 1'b1;
    advance();
    i_add1 = 16'h3333; i_add2 = 16'h4444;
    advance();
    i_valid = 1'b0;
    chk("rst_pre_valid", 32'(o_valid), 32'd1);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(o_valid), 32'd0);
    chk("rst_mid_result", 32'(o_result), 32'd0);
    chk("rst_mid_ovf", 32'(o_ovf), 32'd0);
    exp_q.delete();
    advance();
    advance();
    i_rst_n = 1'b1;
    i_ready = 1'b1;
    seen = 1'b0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      if (o_valid) seen = 1'b1;
      advance();
    end
    chk("rst_no_stale", 32'(seen), 32'd0);

    // Random traffic with random valid/ready against the reference model.
    base = n_out;
    n_in = 0;
    took = 1'b0;
    i_valid = 1'b0;
    for (int cyc = 0; cyc < 20000 && (n_out - base) < 1000; cyc++) begin
      if (!i_valid || took) begin
        if (n_in < 1000 && $urandom_range(0, 9) < 7) begin
          i_add1  = rand_op();
          i_add2  = rand_op();
          i_mode  = 2'($urandom_range(0, 3));
          i_valid = 1'b1;
        end else begin
          i_valid = 1'b0;
        end
      end
      i_ready = ($urandom_range(0, 9) < 7);
      observe();
      advance();
    end
    i_valid = 1'b0;
    chk("rand_delivered", 32'(n_out - base), 32'd1000);
    chk("rand_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
